// File: rtl/mips_mem_pkg.sv
// Shared data-memory constants and the store-buffer entry type.
package mips_mem_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// DEPTH-way load-address comparator; reports the youngest valid matching entry.
module store_buffer_match #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = mips_mem_pkg::ADDR_W,
  parameter int unsigned PW     = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  valid,
  input  logic [PW-1:0]     head,
  input  logic [PW-1:0]     tail,
  input  logic [ADDR_W-1:0] entryAddr [DEPTH],
  input  logic [ADDR_W-1:0] ldAddress,
  output logic              hit,
  output logic [PW-1:0]     hitIdx
);

  // Walk oldest to youngest starting at head so the last match seen is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    logic          done;
    hit    = 1'b0;
    hitIdx = '0;
    idx    = head;
    done   = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (i != 0 && idx == tail) done = 1'b1;
      if (!done && valid[idx] && entryAddr[idx] == ldAddress) begin
        hit    = 1'b1;
        hitIdx = idx;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Four-entry posted-write buffer in front of dataMemory.
// Define STORE_BUFFER_FWD_EN to forward pending stores to loads; otherwise matching loads stall.
module store_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = mips_mem_pkg::ADDR_W,
  parameter int unsigned DATA_W = mips_mem_pkg::DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stEnable,
  input  logic [ADDR_W-1:0]        stAddress,
  input  logic [DATA_W-1:0]        stData,
  input  logic                     ldEnable,
  input  logic [ADDR_W-1:0]        ldAddress,
  output logic [DATA_W-1:0]        ldData,
  output logic                     ldStall,
  output logic                     memWrEnable,
  output logic [ADDR_W-1:0]        memWrAddress,
  output logic [DATA_W-1:0]        memWrData,
  output logic                     memRdEnable,
  output logic [ADDR_W-1:0]        memRdAddress,
  input  logic [DATA_W-1:0]        memRdData,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [ADDR_W-1:0] addrQ [DEPTH];
  logic [DATA_W-1:0] dataQ [DEPTH];
  logic [DEPTH-1:0]  validQ, validD;
  logic [PW-1:0]     headQ, headD, tailQ, tailD;
  logic [CW-1:0]     countQ, countD;
  logic              full, drain, hit;
  logic [PW-1:0]     hitIdx;

  store_buffer_match #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PW     (PW)
  ) u_match (
    .valid     (validQ),
    .head      (headQ),
    .tail      (tailQ),
    .entryAddr (addrQ),
    .ldAddress (ldAddress),
    .hit       (hit),
    .hitIdx    (hitIdx)
  );

  assign full  = (countQ == CW'(DEPTH));
  // A store into a full buffer forces a drain so the push is never refused.
  assign drain = (countQ != '0) && ((!ldEnable && !stEnable) || full || ldStall);

  always_comb begin
    headD  = headQ;
    tailD  = tailQ;
    countD = countQ;
    validD = validQ;
    if (drain) begin
      validD[headQ] = 1'b0;
      headD         = headQ + PW'(1);
    end
    if (stEnable) begin
      validD[tailQ] = 1'b1;
      tailD         = tailQ + PW'(1);
    end
    case ({stEnable, drain})
      2'b10:   countD = countQ + CW'(1);
      2'b01:   countD = countQ - CW'(1);
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      headQ  <= '0;
      tailQ  <= '0;
      countQ <= '0;
      validQ <= '0;
    end else begin
      headQ  <= headD;
      tailQ  <= tailD;
      countQ <= countD;
      validQ <= validD;
    end
  end

  // Payload needs no reset; validQ decides whether a slot is live.
  always_ff @(posedge clk) begin
    if (stEnable) begin
      addrQ[tailQ] <= stAddress;
      dataQ[tailQ] <= stData;
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  assign ldStall = 1'b0;
  assign ldData  = !ldEnable ? '0 : (hit ? dataQ[hitIdx] : memRdData);
`else
  assign ldStall = ldEnable && hit && validQ[hitIdx];
  assign ldData  = ldEnable ? memRdData : '0;
`endif

  assign memWrEnable  = drain;
  assign memWrAddress = addrQ[headQ];
  assign memWrData    = dataQ[headQ];
  assign memRdEnable  = ldEnable;
  assign memRdAddress = ldAddress;
  assign count        = countQ;

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_buffer;
  import mips_mem_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        stEnable, ldEnable;
  logic [4:0]  stAddress, ldAddress;
  logic [31:0] stData;
  logic [31:0] ldData;
  logic        ldStall;
  logic        memWrEnable;
  logic [4:0]  memWrAddress;
  logic [31:0] memWrData;
  logic        memRdEnable;
  logic [4:0]  memRdAddress;
  logic [31:0] memRdData;
  logic [2:0]  count;

  logic [31:0] mem [32] = '{default: 32'h0};

  store_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .stEnable     (stEnable),
    .stAddress    (stAddress),
    .stData       (stData),
    .ldEnable     (ldEnable),
    .ldAddress    (ldAddress),
    .ldData       (ldData),
    .ldStall      (ldStall),
    .memWrEnable  (memWrEnable),
    .memWrAddress (memWrAddress),
    .memWrData    (memWrData),
    .memRdEnable  (memRdEnable),
    .memRdAddress (memRdAddress),
    .memRdData    (memRdData),
    .count        (count)
  );

  always #5 clk = ~clk;

  // dataMemory stand-in: synchronous write, combinational read.
  always @(posedge clk) if (memWrEnable) mem[memWrAddress] <= memWrData;
  assign memRdData = mem[memRdAddress];

  // Reference model: program-order queue of pending stores and the memory image it implies.
  sb_entry_t   q[$];
  logic [31:0] refMem [32];
  int          checks = 0;
  int          errors = 0;
  bit          expDrain;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit modelStall(input bit ld, input logic [4:0] la);
`ifdef STORE_BUFFER_FWD_EN
    return 1'b0;
`else
    if (!ld) return 1'b0;
    foreach (q[i]) if (q[i].addr == la) return 1'b1;
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] modelLoad(input logic [4:0] la);
    for (int i = q.size() - 1; i >= 0; i--) if (q[i].addr == la) return q[i].data;
    return refMem[la];
  endfunction

  // Apply inputs just after an edge and check the combinational response mid-cycle.
  task automatic drive(input bit st, input logic [4:0] sa, input logic [31:0] sd,
                       input bit ld, input logic [4:0] la);
    bit stall;
    stEnable = st; stAddress = sa; stData = sd; ldEnable = ld; ldAddress = la;
    #2;
    stall    = modelStall(ld, la);
    expDrain = (q.size() != 0) && ((!ld && !st) || q.size() == DEPTH || stall);
    checkValue("count", 32'(count), 32'(q.size()));
    checkValue("memWrEnable", 32'(memWrEnable), 32'(expDrain));
    if (expDrain) begin
      checkValue("memWrAddress", 32'(memWrAddress), 32'(q[0].addr));
      checkValue("memWrData", memWrData, q[0].data);
    end
    checkValue("ldStall", 32'(ldStall), 32'(stall));
    checkValue("memRdEnable", 32'(memRdEnable), 32'(ld));
    if (!ld) checkValue("ldDataIdle", ldData, 32'h0);
    else if (!stall) checkValue("ldData", ldData, modelLoad(la));
  endtask

  task automatic advance();
    @(posedge clk);
    if (expDrain) begin
      refMem[q[0].addr] = q[0].data;
      void'(q.pop_front());
    end
    if (stEnable) q.push_back('{addr: stAddress, data: stData});
    #1;
  endtask

  task automatic step(input bit st, input logic [4:0] sa, input logic [31:0] sd,
                      input bit ld, input logic [4:0] la);
    drive(st, sa, sd, ld, la);
    advance();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit          hold;
    bit          st, ld;
    logic [4:0]  sa, la;
    logic [31:0] sd;
    for (int i = 0; i < 32; i++) refMem[i] = 32'h0;
    rst = 1'b1; stEnable = 0; ldEnable = 0; stAddress = 0; ldAddress = 0; stData = 0;
    #12 rst = 1'b0;
    #1;
    checkValue("rstCount", 32'(count), 32'd0);
    checkValue("rstMemWrEnable", 32'(memWrEnable), 32'd0);
    checkValue("rstLdStall", 32'(ldStall), 32'd0);
    @(posedge clk); #1;

    // Single store, then drains on the first idle cycle.
    step(1'b1, 5'd3, 32'h11, 1'b0, 5'd0);
    checkValue("countAfterStore", 32'(count), 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    checkValue("idleDrain", 32'(memWrEnable), 32'd1);
    advance();
    checkValue("mem3", mem[3], 32'h11);
    checkValue("countEmpty", 32'(count), 32'd0);

    // Fill, then push into a full buffer: oldest entry drains on the same edge.
    for (int i = 1; i <= 4; i++) step(1'b1, 5'(i), 32'(i * 10), 1'b0, 5'd0);
    drive(1'b1, 5'd5, 32'd50, 1'b0, 5'd0);
    checkValue("fullForcedDrain", 32'(memWrEnable), 32'd1);
    checkValue("fullDrainAddr", 32'(memWrAddress), 32'd1);
    advance();
    checkValue("fullCount", 32'(count), 32'd4);
    checkValue("mem1", mem[1], 32'd10);
    idle(DEPTH + 1);
    for (int i = 1; i <= 5; i++) checkValue("noLostStore", mem[i], 32'(i * 10));

    // Two stores to one address, then a load of it.
    step(1'b1, 5'd7, 32'd5, 1'b0, 5'd0);
    step(1'b1, 5'd7, 32'd9, 1'b0, 5'd0);
`ifdef STORE_BUFFER_FWD_EN
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    checkValue("fwdYoungest", ldData, 32'd9);
    checkValue("mem7Old", mem[7], 32'h0);
    advance();
`else
    for (int n = 0; n < DEPTH + 2; n++) if (modelStall(1'b1, 5'd7)) step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7);
    checkValue("stallReleased", 32'(ldStall), 32'd0);
    checkValue("ldAfterStall", ldData, 32'd9);
    advance();
`endif
    idle(DEPTH);

    // Three pending stores discarded by an asynchronous reset mid-cycle.
    for (int i = 0; i < 3; i++) step(1'b1, 5'(20 + i), 32'hA0 + 32'(i), 1'b1, 5'd30);
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd30);
    rst = 1'b1;
    #1;
    checkValue("midRstCount", 32'(count), 32'd0);
    checkValue("midRstMemWrEnable", 32'(memWrEnable), 32'd0);
    #1 rst = 1'b0;
    q.delete();
    expDrain = 1'b0;
    advance();
    idle(2);
    for (int i = 20; i < 23; i++) checkValue("rstDiscard", mem[i], refMem[i]);

    // 3*DEPTH back-to-back stores wrap both pointers.
    for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, 5'($urandom_range(8, 15)), $urandom, 1'b0, 5'd0);
    idle(DEPTH + 1);
    for (int i = 8; i < 16; i++) checkValue("wrapMem", mem[i], refMem[i]);

    // Random mixed traffic; a stalled load is held with no new store until it clears.
    hold = 1'b0;
    la   = 5'd0;
    for (int c = 0; c < 400; c++) begin
      if (hold) begin
        st = 1'b0; ld = 1'b1;
      end else begin
        st = ($urandom_range(0, 2) != 0);
        ld = ($urandom_range(0, 2) == 0);
        la = 5'($urandom_range(0, 7));
      end
      sa = 5'($urandom_range(0, 7));
      sd = $urandom;
      hold = modelStall(ld, la);
      step(st, sa, sd, ld, la);
      hold = hold && modelStall(1'b1, la);
    end
    idle(DEPTH + 2);
    for (int i = 0; i < 32; i++) checkValue("finalMem", mem[i], refMem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
